// File: rtl/dma_wr_pkg.sv
// Shared types and constants for the DMA write controller.
package dma_wr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam int CL_BYTES           = 64;
    localparam int CL_SHIFT           = $clog2(CL_BYTES);
    localparam int DEFAULT_DATA_WIDTH = 512;

endpackage

// File: rtl/dma_wr_ctrl.sv
// DMA write controller: streams `size` cache lines from the source port to
// the write channel at consecutive line addresses, then waits for all acks.
module dma_wr_ctrl
    import dma_wr_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int SIZE_WIDTH = 17,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  go,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [SIZE_WIDTH-1:0] size,
    output logic                  done,
    input  logic                  src_valid,
    input  logic [DATA_WIDTH-1:0] src_data,
    output logic                  src_ready,
    output logic                  dma_wr_en,
    output logic [ADDR_WIDTH-1:0] dma_wr_addr,
    output logic [DATA_WIDTH-1:0] dma_wr_data,
    input  logic                  dma_wr_full,
    input  logic                  dma_wr_ack
);

    // One extra bit so a maximal size never wraps the counters.
    localparam int CW = SIZE_WIDTH + 1;

    state_t                state;
    state_t                state_next;
    logic [ADDR_WIDTH-1:0] base;
    logic [SIZE_WIDTH-1:0] size_q;
    logic [CW-1:0]         issued;
    logic [CW-1:0]         acked;
    logic [CW-1:0]         size_ext;
    logic                  accept;
    logic                  issue;
    logic                  last_issue;
    logic                  ack_take;

    assign size_ext   = {1'b0, size_q};
    assign accept     = go && (state == ST_IDLE || state == ST_DONE);
    assign issue      = rst_n && (state == ST_WRITE) && src_valid && !dma_wr_full;
    assign last_issue = issue && ((issued + CW'(1)) == size_ext);
    assign ack_take   = dma_wr_ack && (state == ST_WRITE || state == ST_DRAIN)
                        && (acked != size_ext);

    assign dma_wr_en   = issue;
    assign src_ready   = issue;
    assign dma_wr_data = src_data;
    assign dma_wr_addr = base + (ADDR_WIDTH'(issued) << CL_SHIFT);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            done   <= 1'b0;
            base   <= '0;
            size_q <= '0;
            issued <= '0;
            acked  <= '0;
        end else begin
            state <= state_next;
            done  <= (state_next == ST_DONE);
            if (accept) begin
                base   <= wr_addr;
                size_q <= size;
                issued <= '0;
                acked  <= '0;
            end else begin
                if (issue) begin
                    issued <= issued + CW'(1);
                end
                if (ack_take) begin
                    acked <= acked + CW'(1);
                end
            end
        end
    end

    // DRAIN compares the registered ack count, so it always lasts at least one cycle.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (go) begin
                    state_next = (size == '0) ? ST_DONE : ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (last_issue) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (acked == size_ext) begin
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_dma_wr_ctrl.sv
// Self-checking bench for dma_wr_ctrl: scoreboard of expected write requests
// plus per-scenario tasks checking done timing, issue counts and reset abort.
module tb_dma_wr_ctrl;

    localparam int AW = 64;
    localparam int SW = 17;
    localparam int DW = 512;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          go;
    logic [AW-1:0] wr_addr;
    logic [SW-1:0] size;
    logic          done;
    logic          src_valid;
    logic [DW-1:0] src_data;
    logic          src_ready;
    logic          dma_wr_en;
    logic [AW-1:0] dma_wr_addr;
    logic [DW-1:0] dma_wr_data;
    logic          dma_wr_full;
    logic          dma_wr_ack;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   ack_q[$];
    int   issue_cyc_q[$];

    int compared     = 0;
    int mismatched   = 0;
    int cyc          = 0;
    int src_idx      = 0;
    int issue_count  = 0;
    int ready_count  = 0;
    int src_mode     = 0;
    int full_from    = 0;
    int full_to      = -1;
    int ack_delay    = 3;
    int last_ack_cyc = -1;

    always #5 clk = ~clk;

    dma_wr_ctrl #(
        .ADDR_WIDTH(AW),
        .SIZE_WIDTH(SW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .go         (go),
        .wr_addr    (wr_addr),
        .size       (size),
        .done       (done),
        .src_valid  (src_valid),
        .src_data   (src_data),
        .src_ready  (src_ready),
        .dma_wr_en  (dma_wr_en),
        .dma_wr_addr(dma_wr_addr),
        .dma_wr_data(dma_wr_data),
        .dma_wr_full(dma_wr_full),
        .dma_wr_ack (dma_wr_ack)
    );

    function automatic logic [DW-1:0] pattern(input int idx);
        logic [DW-1:0] v;
        for (int k = 0; k < DW / 32; k++) begin
            v[k*32 +: 32] = 32'(idx) * 32'h9E37_79B9 + 32'(k) * 32'h0101_0101 + 32'h1234_5678;
        end
        return v;
    endfunction

    // Source, full and ack driver: updates just after each rising edge.
    initial begin
        src_valid   = 1'b0;
        src_data    = '0;
        dma_wr_full = 1'b0;
        dma_wr_ack  = 1'b0;
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            case (src_mode)
                0:       src_valid = 1'b1;
                1:       src_valid = cyc[0];
                default: src_valid = 1'b0;
            endcase
            src_data    = pattern(src_idx);
            dma_wr_full = (cyc >= full_from) && (cyc <= full_to);
            dma_wr_ack  = 1'b0;
            while (ack_q.size() > 0 && ack_q[0] < cyc) void'(ack_q.pop_front());
            if (ack_q.size() > 0 && ack_q[0] == cyc) begin
                void'(ack_q.pop_front());
                dma_wr_ack   = 1'b1;
                last_ack_cyc = cyc;
            end
        end
    end

    // Request monitor: pops the scoreboard on every issued write.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                compared++;
                if (dma_wr_en !== 1'b0 || src_ready !== 1'b0) begin
                    mismatched++;
                    $display("[TB] FAIL reset_quiet: en=%b ready=%b required 0/0", dma_wr_en, src_ready);
                end
            end
            if (dma_wr_en === 1'b1 || src_ready === 1'b1) begin
                compared++;
                if (src_ready !== dma_wr_en) begin
                    mismatched++;
                    $display("[TB] FAIL ready_vs_en: ready=%b en=%b required equal", src_ready, dma_wr_en);
                end
            end
            if (dma_wr_en === 1'b1) begin
                compared++;
                if (dma_wr_full !== 1'b0 || src_valid !== 1'b1) begin
                    mismatched++;
                    $display("[TB] FAIL issue_gate: issued with full=%b valid=%b", dma_wr_full, src_valid);
                end
                compared++;
                if (exp_q.size() == 0) begin
                    mismatched++;
                    $display("[TB] FAIL unexpected_issue: addr=%h with nothing expected", dma_wr_addr);
                end else begin
                    e = exp_q.pop_front();
                    if (dma_wr_addr !== e.addr || dma_wr_data !== e.data) begin
                        mismatched++;
                        $display("[TB] FAIL scoreboard: addr=%h expected %h, data=%h expected %h",
                                 dma_wr_addr, e.addr, dma_wr_data, e.data);
                    end
                end
                issue_count++;
                issue_cyc_q.push_back(cyc);
                ack_q.push_back(cyc + ack_delay);
                src_idx++;
            end
            if (src_ready === 1'b1) ready_count++;
        end
    end

    initial begin
        #400000;
        mismatched++;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic pulse_go(input logic [AW-1:0] a, input int n, input bit accept, output int gcyc);
        exp_t e;
        @(posedge clk);
        #1;
        if (accept) begin
            for (int i = 0; i < n; i++) begin
                e.addr = a + AW'(i) * AW'(64);
                e.data = pattern(src_idx + exp_q.size());
                exp_q.push_back(e);
            end
        end
        go      = 1'b1;
        wr_addr = a;
        size    = SW'(n);
        gcyc    = cyc;
        @(posedge clk);
        #1;
        go = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok, output int dcyc);
        ok   = 1'b0;
        dcyc = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) begin
                ok   = 1'b1;
                dcyc = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        compared++;
        if (done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_done: got %b required 0", done);
        end
        compared++;
        if (dma_wr_en !== 1'b0 || src_ready !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_outputs: en=%b ready=%b required 0/0", dma_wr_en, src_ready);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        compared++;
        if (done !== 1'b0 || dma_wr_en !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL idle_after_reset: done=%b en=%b required 0/0", done, dma_wr_en);
        end
    endtask

    task automatic test_size_zero();
        int g;
        int n0 = issue_count;
        pulse_go(64'h5000, 0, 1'b1, g);
        @(posedge clk);
        #1;
        compared++;
        if (done !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL size0_done: got %b required 1", done);
        end
        repeat (4) @(negedge clk);
        #1;
        compared++;
        if (issue_count != n0) begin
            mismatched++;
            $display("[TB] FAIL size0_no_issue: issues %0d required 0", issue_count - n0);
        end
    endtask

    task automatic test_basic();
        int g, dc;
        bit ok;
        int n0 = issue_count;
        pulse_go(64'h1000, 4, 1'b1, g);
        compared++;
        if (done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL basic_done_clear: got %b required 0", done);
        end
        wait_done(60, ok, dc);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("[TB] FAIL basic_timeout: done never rose");
        end
        compared++;
        if (issue_count - n0 != 4) begin
            mismatched++;
            $display("[TB] FAIL basic_issues: got %0d required 4", issue_count - n0);
        end else begin
            compared++;
            if (issue_cyc_q[n0+3] - issue_cyc_q[n0] != 3) begin
                mismatched++;
                $display("[TB] FAIL basic_back_to_back: span %0d cycles required 3",
                         issue_cyc_q[n0+3] - issue_cyc_q[n0]);
            end
        end
        // Last ack is captured at the end of its cycle, DRAIN sees the count next cycle.
        compared++;
        if (dc != last_ack_cyc + 2) begin
            mismatched++;
            $display("[TB] FAIL basic_done_timing: done cycle %0d required %0d", dc, last_ack_cyc + 2);
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL basic_leftover: %0d expected writes missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_full_toggle();
        int g, dc;
        bit ok;
        int n0 = issue_count;
        int r0 = ready_count;
        src_mode = 1;
        pulse_go(64'h7000, 3, 1'b1, g);
        full_from = g + 2;
        full_to   = g + 5;
        wait_done(80, ok, dc);
        compared++;
        if (!ok) begin
            mismatched++;
            $display("[TB] FAIL full_timeout: done never rose");
        end
        compared++;
        if (issue_count - n0 != 3) begin
            mismatched++;
            $display("[TB] FAIL full_issues: got %0d required 3", issue_count - n0);
        end
        compared++;
        if (ready_count - r0 != 3) begin
            mismatched++;
            $display("[TB] FAIL full_ready_count: got %0d required 3", ready_count - r0);
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL full_leftover: %0d missing required 0", exp_q.size());
        end
        src_mode  = 0;
        full_from = 0;
        full_to   = -1;
    endtask

    task automatic test_go_ignored();
        int g, g2, dc;
        bit ok;
        int n0 = issue_count;
        pulse_go(64'h2000, 4, 1'b1, g);
        pulse_go(64'h9000, 2, 1'b0, g2);
        wait_done(60, ok, dc);
        compared++;
        if (!ok || issue_count - n0 != 4) begin
            mismatched++;
            $display("[TB] FAIL regate_issues: done=%b issues %0d required 1/4", ok, issue_count - n0);
        end
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL regate_leftover: %0d missing required 0", exp_q.size());
        end
        n0 = issue_count;
        pulse_go(64'h3000, 1, 1'b1, g);
        compared++;
        if (done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL restart_done_drop: got %b required 0", done);
        end
        wait_done(40, ok, dc);
        compared++;
        if (!ok || issue_count - n0 != 1 || exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL restart_complete: done=%b issues %0d required 1/1", ok, issue_count - n0);
        end
    endtask

    task automatic test_reset_abort();
        int g, dc, n1;
        bit ok;
        bit reached = 1'b0;
        int n0 = issue_count;
        ack_delay = 6;
        pulse_go(64'h4000, 8, 1'b1, g);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (issue_count - n0 >= 2) begin
                reached = 1'b1;
                break;
            end
        end
        compared++;
        if (!reached) begin
            mismatched++;
            $display("[TB] FAIL abort_start: only %0d issues required 2", issue_count - n0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        n1 = issue_count;
        repeat (10) @(negedge clk);
        #1;
        compared++;
        if (n1 - n0 != 2 || issue_count != n1) begin
            mismatched++;
            $display("[TB] FAIL abort_issues: before %0d after %0d required 2/0", n1 - n0, issue_count - n1);
        end
        compared++;
        if (done !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL abort_done: got %b required 0", done);
        end
        ack_delay = 3;
        n0 = issue_count;
        pulse_go(64'h6000, 1, 1'b1, g);
        wait_done(40, ok, dc);
        compared++;
        if (!ok || issue_count - n0 != 1 || exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL abort_fresh: done=%b issues %0d required 1/1", ok, issue_count - n0);
        end
    endtask

    task automatic test_wrap();
        int g, dc;
        bit ok;
        int n0 = issue_count;
        pulse_go(64'hFFFF_FFFF_FFFF_FFC0, 2, 1'b1, g);
        wait_done(40, ok, dc);
        compared++;
        if (!ok || issue_count - n0 != 2 || exp_q.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL wrap_complete: done=%b issues %0d left %0d required 1/2/0",
                     ok, issue_count - n0, exp_q.size());
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        go      = 1'b0;
        wr_addr = '0;
        size    = '0;
        test_reset();
        test_size_zero();
        test_basic();
        test_full_toggle();
        test_go_ignored();
        test_reset_abort();
        test_wrap();
        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
